// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit and the data memory.
interface mem_access_unit_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;

  // Access unit side: issues requests, receives read data and ack.
  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_rdata_i, dmem_ack_i
  );

  // Memory side: accepts requests, returns read data and ack.
  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one data-memory access per instruction,
// stalls the pipeline until ack or timeout, and returns extended load data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic [2:0]         funct3_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        readMem_o,
  output logic               stall_o,
  output logic               access_fault_o,
  output logic               bus_err_o,
  mem_access_unit_if.master  dmem
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rm_q, rm_d;
  logic              berr_q, berr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              ld_q, ld_d;

  logic              mem_op, illegal_f3, misaligned, start;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  // Fault decode: illegal size encodings and misaligned halfword/word accesses.
  always_comb begin
    mem_op         = valid_i & (mem_read_i | mem_write_i);
    illegal_f3     = (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11);
    misaligned     = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                     ((funct3_i == 3'b010) & (addr_i[1:0] != 2'b00));
    access_fault_o = mem_op & (illegal_f3 | misaligned);
    start          = mem_op & ~access_fault_o;
  end

  // Store lane steering: replicate data across lanes, enable only the target bytes.
  always_comb begin
    st_be   = 4'b1111;
    st_data = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        st_be   = 4'b0001 << addr_i[1:0];
        st_data = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        st_be   = addr_i[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_i[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata_i;
      end
    endcase
  end

  // Load extraction from the returned word using the size/offset latched at start.
  always_comb begin
    ld_byte = 8'h00;
    ld_half = off_q[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
    case (off_q)
      2'd0:    ld_byte = dmem.dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem.dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem.dmem_rdata_i[23:16];
      default: ld_byte = dmem.dmem_rdata_i[31:24];
    endcase
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = dmem.dmem_rdata_i;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rm_d    = rm_q;
    berr_d  = 1'b0;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    ld_d    = ld_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stall_o = 1'b1;
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = mem_write_i;
          addr_d  = {addr_i[31:2], 2'b00};
          be_d    = st_be;
          wdata_d = st_data;
          cnt_d   = '0;
          f3_d    = funct3_i;
          off_d   = addr_i[1:0];
          ld_d    = ~mem_write_i;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (dmem.dmem_ack_i) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (ld_q) rm_d = ld_data;
          state_d = DONE;
        end else if (cnt_q >= CNT_LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          rm_d    = 32'h0;
          berr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rm_q    <= 32'h0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rm_q    <= rm_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      ld_q    <= ld_d;
    end
  end

  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_be_o    = be_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign readMem_o         = rm_q;
  assign bus_err_o         = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a 4-cycle bus timeout.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] readMem_o;
  logic        stall_o;
  logic        access_fault_o;
  logic        bus_err_o;

  mem_access_unit_if dif ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .mem_read_i     (mem_read_i),
    .mem_write_i    (mem_write_i),
    .funct3_i       (funct3_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .readMem_o      (readMem_o),
    .stall_o        (stall_o),
    .access_fault_o (access_fault_o),
    .bus_err_o      (bus_err_o),
    .dmem           (dif)
  );

  req_t        sb_req[$];
  logic [31:0] sb_rm[$];
  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_rm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    if (f3[1:0] == 2'b00) begin
      case (off)
        2'd0:    be = 4'b0001;
        2'd1:    be = 4'b0010;
        2'd2:    be = 4'b0100;
        default: be = 4'b1000;
      endcase
    end else if (f3[1:0] == 2'b01) begin
      be = (off == 2'd2) ? 4'b1100 : 4'b0011;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    if (f3[1:0] == 2'b00)      d = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    else if (f3[1:0] == 2'b01) d = {wd[15:0], wd[15:0]};
    else                       d = wd;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b100:  r = {24'h0, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b101:  r = {16'h0, sh[15:0]};
      default: r = rdata;
    endcase
    return r;
  endfunction

  task automatic go_idle();
    valid_i     = 1'b0;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
  endtask

  // Enters just after a rising edge, leaves just after the edge ending DONE.
  // ack_dly < 0 means memory never acks (timeout path).
  task automatic run_access(input string nm, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rword,
                            input int ack_dly);
    req_t        r;
    logic [31:0] e;
    valid_i     = 1'b1;
    mem_read_i  = rd;
    mem_write_i = wr;
    funct3_i    = f3;
    addr_i      = a;
    wdata_i     = wd;
    r.we    = wr;
    r.addr  = {a[31:2], 2'b00};
    r.be    = model_be(f3, a[1:0]);
    r.wdata = model_wdata(f3, wd);
    sb_req.push_back(r);
    if (ack_dly < 0)  sb_rm.push_back(32'h0);
    else if (!wr)     sb_rm.push_back(model_load(f3, a[1:0], rword));
    else              sb_rm.push_back(exp_rm);
    @(negedge clk);
    check({nm, ".start_stall"}, 32'(stall_o), 32'd1);
    check({nm, ".start_fault"}, 32'(access_fault_o), 32'd0);
    check({nm, ".start_req"}, 32'(dif.dmem_req_o), 32'd0);
    @(posedge clk); #1;
    for (int c = 0; c < int'(TO); c++) begin
      if (c == ack_dly) begin
        dif.dmem_ack_i   = 1'b1;
        dif.dmem_rdata_i = rword;
      end
      @(negedge clk);
      check({nm, ".busy_stall"}, 32'(stall_o), 32'd1);
      check({nm, ".busy_req"}, 32'(dif.dmem_req_o), 32'd1);
      if (c == 0 && dif.dmem_req_o === 1'b1) begin
        r = sb_req.pop_front();
        check({nm, ".we"}, 32'(dif.dmem_we_o), 32'(r.we));
        check({nm, ".addr"}, dif.dmem_addr_o, r.addr);
        check({nm, ".be"}, 32'(dif.dmem_be_o), 32'(r.be));
        check({nm, ".wdata"}, dif.dmem_wdata_o, r.wdata);
      end
      @(posedge clk); #1;
      dif.dmem_ack_i = 1'b0;
      if (c == ack_dly) break;
    end
    @(negedge clk);
    e = sb_rm.pop_front();
    exp_rm = e;
    check({nm, ".done_stall"}, 32'(stall_o), 32'd0);
    check({nm, ".done_req"}, 32'(dif.dmem_req_o), 32'd0);
    check({nm, ".done_we"}, 32'(dif.dmem_we_o), 32'd0);
    check({nm, ".readMem"}, readMem_o, e);
    check({nm, ".bus_err"}, 32'(bus_err_o), (ack_dly < 0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_fault(input string nm, input logic [2:0] f3, input logic [31:0] a);
    valid_i     = 1'b1;
    mem_read_i  = 1'b1;
    mem_write_i = 1'b0;
    funct3_i    = f3;
    addr_i      = a;
    @(negedge clk);
    check({nm, ".fault"}, 32'(access_fault_o), 32'd1);
    check({nm, ".stall"}, 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, ".req"}, 32'(dif.dmem_req_o), 32'd0);
    check({nm, ".readMem"}, readMem_o, exp_rm);
    @(posedge clk); #1;
    go_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_rm = 32'h0;
    rst_n = 1'b0;
    go_idle();
    funct3_i = 3'b000;
    addr_i = 32'h0;
    wdata_i = 32'h0;
    dif.dmem_ack_i = 1'b0;
    dif.dmem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req", 32'(dif.dmem_req_o), 32'd0);
    check("rst.we", 32'(dif.dmem_we_o), 32'd0);
    check("rst.addr", dif.dmem_addr_o, 32'h0);
    check("rst.be", 32'(dif.dmem_be_o), 32'd0);
    check("rst.wdata", dif.dmem_wdata_o, 32'h0);
    check("rst.readMem", readMem_o, 32'h0);
    check("rst.bus_err", 32'(bus_err_o), 32'd0);
    check("rst.stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_access("lb103", 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 0);
    run_access("sh202", 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1);
    go_idle();
    @(posedge clk); #1;

    run_fault("lw006", 3'b010, 32'h0000_0006);
    run_fault("lh101", 3'b001, 32'h0000_0101);
    run_fault("f3_011", 3'b011, 32'h0000_0100);

    run_access("lhu_to", 1'b1, 1'b0, 3'b101, 32'h0000_0042, 32'h0, 32'h0, -1);
    go_idle();
    @(negedge clk);
    check("lhu_to.err_once", 32'(bus_err_o), 32'd0);
    check("lhu_to.idle_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;

    run_access("lw010", 1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 0);
    run_access("sw014", 1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'h1122_3344, 32'h0, 3);
    run_access("lh102", 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 2);
    run_access("lbu101", 1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h0000_F000, 1);
    run_access("sb301", 1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_005A, 32'h0, 0);
    run_access("lhu100", 1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_ABCD, 0);
    run_access("lb000", 1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'hFFFF_FF7F, 0);
    go_idle();

    // Stray ack while idle must not disturb anything.
    @(posedge clk); #1;
    dif.dmem_ack_i = 1'b1;
    dif.dmem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stray.stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    dif.dmem_ack_i = 1'b0;
    @(negedge clk);
    check("stray.req", 32'(dif.dmem_req_o), 32'd0);
    check("stray.readMem", readMem_o, exp_rm);

    // Reset in the middle of a BUSY access, then late acks.
    @(posedge clk); #1;
    valid_i = 1'b1;
    mem_read_i = 1'b1;
    funct3_i = 3'b010;
    addr_i = 32'h0000_0400;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstbusy.req_before", 32'(dif.dmem_req_o), 32'd1);
    #2;
    rst_n = 1'b0;
    go_idle();
    #1;
    check("rstbusy.req", 32'(dif.dmem_req_o), 32'd0);
    check("rstbusy.be", 32'(dif.dmem_be_o), 32'd0);
    check("rstbusy.readMem", readMem_o, 32'h0);
    check("rstbusy.stall", 32'(stall_o), 32'd0);
    exp_rm = 32'h0;
    @(posedge clk); #1;
    dif.dmem_ack_i = 1'b1;
    dif.dmem_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    dif.dmem_ack_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dif.dmem_ack_i = 1'b1;
    @(posedge clk); #1;
    dif.dmem_ack_i = 1'b0;
    @(negedge clk);
    check("late_ack.req", 32'(dif.dmem_req_o), 32'd0);
    check("late_ack.readMem", readMem_o, 32'h0);
    check("late_ack.bus_err", 32'(bus_err_o), 32'd0);
    check("late_ack.stall", 32'(stall_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of BUSY cycles waited for dmem_ack_i before abort (legal range 1..255).
REQ-002 SHALL use one clock and an asynchronous, active-low reset; all state updates occur on the rising edge of clk.
REQ-003 clk  in  1  pipeline clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 valid_i  in  1  EX/MEM stage holds a valid instruction.
REQ-006 mem_read_i  in  1  instruction is a load.
REQ-007 mem_write_i  in  1  instruction is a store.
REQ-008 funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 addr_i  in  32  byte address, i.e. the ALU result.
REQ-010 wdata_i  in  32  store data from rs2.
REQ-011 dmem_req_o  out  1  data-memory request, registered.
REQ-012 dmem_we_o  out  1  write enable, registered.
REQ-013 dmem_addr_o  out  32  word address {addr_i[31:2],2'b00}, registered.
REQ-014 dmem_be_o  out  4  byte enables, registered.
REQ-015 dmem_wdata_o  out  32  lane-aligned store data, registered.
REQ-016 dmem_rdata_i  in  32  read word, valid when dmem_ack_i=1.
REQ-017 dmem_ack_i  in  1  access complete, one-cycle pulse.
REQ-018 readMem_o  out  32  extended load data, registered; feeds MEM/WB readMem_i.
REQ-019 stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-020 access_fault_o  out  1  combinational, misaligned or illegal funct3.
REQ-021 bus_err_o  out  1  one-cycle pulse on timeout.

Function
REQ-022 SHALL implement states IDLE, BUSY and DONE.
REQ-023 start = valid_i & (mem_read_i | mem_write_i) & ~access_fault_o, evaluated only in IDLE.
REQ-024 access_fault_o SHALL be 1 when valid_i & (rd|wr) and one of: H/HU with addr_i[0]=1; W with addr_i[1:0]!=0; funct3 in {011,110,111}. A faulting access issues no request and no stall, and holds readMem_o.
REQ-025 IDLE & start: next state BUSY; register req=1, we=mem_write_i, address, byte enables and data; stall_o=1 combinationally in this cycle.
REQ-026 BUSY: stall_o=1; request fields held stable until ack.
REQ-027 BUSY & dmem_ack_i: req/we cleared next edge; load data captured into readMem_o; next state DONE.
REQ-028 BUSY with no ack for TIMEOUT_CYCLES cycles: clear req; readMem_o=0; bus_err_o=1 for one cycle; next state DONE.
REQ-029 DONE: stall_o=0 for exactly one cycle, so MEM/WB latches readMem_o; valid_i is ignored in DONE; next state IDLE.
REQ-030 Minimum latency: start at cycle N with ack at N+1 gives stall_o high in N and N+1, and low in N+2.
REQ-031 Store lanes: SB be=4'b0001<<addr_i[1:0], data={4{wdata_i[7:0]}}; SH be=addr_i[1]?4'b1100:4'b0011, data={2{wdata_i[15:0]}}; SW be=4'b1111, data=wdata_i.
REQ-032 Load extraction: the byte or half is selected by addr_i[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged. For stores, readMem_o is unchanged.
REQ-033 Timeout counter is 8 bits, cleared on entry to BUSY, and does not wrap.
REQ-034 An ack arriving outside BUSY SHALL be ignored.
REQ-035 Non-memory or invalid instructions: stall_o=0 and readMem_o held.

Reset
REQ-036 rst_n=0 SHALL immediately force: state IDLE, dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_be_o=0, dmem_wdata_o=0, readMem_o=0, bus_err_o=0, counter=0. An in-flight access is abandoned, and a late ack after reset is ignored.

Verification
REQ-037 LB, addr=0x103, rdata=0x80FF_FF00, ack 1 cycle after req -> readMem_o=0xFFFF_FF80; stall_o high 2 cycles.
REQ-038 SH, addr=0x202, wdata=0x0000_ABCD -> dmem_addr_o=0x200, be=1100, wdata=0xABCD_ABCD, we=1.
REQ-039 LW, addr=0x006 -> access_fault_o=1, dmem_req_o stays 0, stall_o=0.
REQ-040 LHU, no ack, TIMEOUT_CYCLES=4 -> req drops after 4 BUSY cycles; bus_err_o pulses once; readMem_o=0.
REQ-041 rst_n low while in BUSY, then ack pulses -> req=0 asynchronously; state IDLE; readMem_o=0.
REQ-042 Back-to-back LW/SW with ack delays 0 and 3 cycles -> exactly one DONE cycle per access, and no duplicate request.
